// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// Picks one of NREQ write requesters per cycle, starting the scan just after
// the most recent winner. It registers the winning address and data so the
// register file sees the write one cycle after the grant. With ZERO_GUARD set,
// writes to register 0 are still granted (so the requester is released) but
// are never issued to the array.
module regfile_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int ZERO_GUARD = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     write,
    output logic [AW-1:0]            wraddr,
    output logic [DW-1:0]            wrdata,
    output logic [$clog2(NREQ)-1:0]  last_gnt,
    output logic                     idle
);

    localparam int IW = $clog2(NREQ);

    logic [AW-1:0] addr_arr [NREQ];
    logic [DW-1:0] data_arr [NREQ];
    logic          found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand_idx;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    logic          win_zero;
    int            cand;

    // Split the flattened request buses into per-requester fields
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*AW +: AW];
            data_arr[i] = req_data[i*DW +: DW];
        end
    end

    // Scan from the requester after the last winner, wrapping, and take the first one asking
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        cand_idx = '0;
        cand     = 0;
        win_addr = '0;
        win_data = '0;
        gnt      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last_gnt) + k) % NREQ;
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                win_idx       = cand_idx;
                win_addr      = addr_arr[cand_idx];
                win_data      = data_arr[cand_idx];
                gnt[cand_idx] = 1'b1;
            end
        end
        if (rst) begin
            found = 1'b0;
            gnt   = '0;
        end
    end

    // A grant aimed at register 0 is swallowed when the guard is enabled
    assign win_zero = (ZERO_GUARD != 0) && (win_addr == '0);

    // Register the winner; write drops whenever nothing was granted
    always_ff @(posedge clk) begin
        if (rst) begin
            write    <= 1'b0;
            wraddr   <= '0;
            wrdata   <= '0;
            last_gnt <= IW'(NREQ - 1);
        end else if (found) begin
            write    <= !win_zero;
            wraddr   <= win_addr;
            wrdata   <= win_data;
            last_gnt <= win_idx;
        end else begin
            write    <= 1'b0;
        end
    end

    assign idle = (req == '0) && !write;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed vectors with hand-computed grants,
// a scoreboard queue of expected register-file writes consumed by a monitor,
// and a randomised burst checked against a register-file model.
module tb_regfile_wr_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [19:0]  reqAddr;
    logic [127:0] reqData;

    logic [3:0]   gnt;
    logic         write;
    logic [4:0]   wraddr;
    logic [31:0]  wrdata;
    logic [1:0]   lastGnt;
    logic         idle;

    logic [3:0]   gnt0;
    logic         write0;
    logic [4:0]   wraddr0;
    logic [31:0]  wrdata0;
    logic [1:0]   lastGnt0;
    logic         idle0;

    regfile_wr_arbiter #(.NREQ(4), .AW(5), .DW(32), .ZERO_GUARD(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(reqAddr), .req_data(reqData),
        .gnt(gnt), .write(write), .wraddr(wraddr), .wrdata(wrdata),
        .last_gnt(lastGnt), .idle(idle)
    );

    regfile_wr_arbiter #(.NREQ(4), .AW(5), .DW(32), .ZERO_GUARD(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .req_addr(reqAddr), .req_data(reqData),
        .gnt(gnt0), .write(write0), .wraddr(wraddr0), .wrdata(wrdata0),
        .last_gnt(lastGnt0), .idle(idle0)
    );

    int passCount = 0;
    int totalCount = 0;

    logic [4:0]  addrArr [4];
    logic [31:0] dataArr [4];
    logic [36:0] expQ [$];
    logic [31:0] modelRf [32];
    logic        modelWritten [32];
    logic [31:0] rf [32];
    int          modelLast = 3;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file driven by the arbiter's write port
    always @(posedge clk) begin
        if (write) rf[wraddr] <= wrdata;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference round-robin pick, independent of the DUT
    function automatic logic [3:0] rrModel(input logic [3:0] r, input int last);
        logic [3:0] res;
        res = 4'b0000;
        for (int k = 4; k >= 1; k--) begin
            if (r[(last + k) % 4]) res = 4'b0001 << ((last + k) % 4);
        end
        return res;
    endfunction

    // One clock cycle of stimulus; checks gnt and records expected writes
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] expGnt, input logic doRst);
        @(posedge clk);
        #1;
        rst = doRst;
        req = r;
        for (int i = 0; i < 4; i++) begin
            reqAddr[i*5 +: 5]   = addrArr[i];
            reqData[i*32 +: 32] = dataArr[i];
        end
        @(negedge clk);
        checkOutput("gnt", 64'(gnt), 64'(expGnt));
        if (doRst) begin
            modelLast = 3;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (expGnt[i]) begin
                    modelLast = i;
                    if (addrArr[i] != 5'd0) begin
                        expQ.push_back({addrArr[i], dataArr[i]});
                        modelRf[addrArr[i]]      = dataArr[i];
                        modelWritten[addrArr[i]] = 1'b1;
                    end
                end
            end
        end
    endtask

    // Monitor: every issued write must match the oldest expected write
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (write === 1'b1) begin
                totalCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL spurious_write: got addr %0h data %0h expected no write", wraddr, wrdata);
                end else begin
                    e = expQ.pop_front();
                    if ({wraddr, wrdata} === e) passCount++;
                    else $display("[TB] FAIL write_data: got %0h expected %0h", {wraddr, wrdata}, e);
                end
            end
        end
    end

    initial begin
        logic [3:0] gntSeq [4];
        logic [4:0] addrSeq [4];
        logic [3:0] pending;
        logic [3:0] expG;
        int         waitCnt [4];
        int         issued;
        int         cycles;

        rst = 1'b1;
        req = 4'b0000;
        reqAddr = '0;
        reqData = '0;
        for (int i = 0; i < 4; i++) begin
            addrArr[i] = 5'd0;
            dataArr[i] = 32'd0;
        end
        for (int a = 0; a < 32; a++) begin
            modelRf[a] = 32'd0;
            modelWritten[a] = 1'b0;
        end

        // Reset state
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("rst_write", 64'(write), 64'(0));
        checkOutput("rst_wraddr", 64'(wraddr), 64'(0));
        checkOutput("rst_wrdata", 64'(wrdata), 64'(0));
        checkOutput("rst_last_gnt", 64'(lastGnt), 64'(3));
        checkOutput("rst_idle", 64'(idle), 64'(1));

        // Single request, two-edge latency, then idle
        addrArr[0] = 5'd3;
        dataArr[0] = 32'hDEADBEEF;
        applyStimulus(4'b0001, 4'b0001, 1'b0);
        checkOutput("idle_busy", 64'(idle), 64'(0));
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("single_write", 64'(write), 64'(1));
        checkOutput("single_wraddr", 64'(wraddr), 64'(3));
        checkOutput("single_wrdata", 64'(wrdata), 64'(32'hDEADBEEF));
        checkOutput("single_last_gnt", 64'(lastGnt), 64'(0));
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("single_write_off", 64'(write), 64'(0));
        checkOutput("single_idle", 64'(idle), 64'(1));

        // All four requesting: strict rotation and back-to-back writes
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            addrArr[i] = 5'(i + 1);
            dataArr[i] = 32'h1000 + 32'(i);
        end
        gntSeq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        addrSeq = '{5'd1, 5'd2, 5'd3, 5'd4};
        applyStimulus(4'b1111, 4'b0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1111, gntSeq[k], 1'b0);
            checkOutput("rr_write", 64'(write), 64'(1));
            checkOutput("rr_wraddr", 64'(wraddr), 64'(addrSeq[k]));
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("rr_last_write", 64'(write), 64'(1));
        checkOutput("rr_last_wraddr", 64'(wraddr), 64'(1));
        checkOutput("rr_last_gnt", 64'(lastGnt), 64'(0));

        // Wrap order: with last_gnt=1, requester 0 beats requester 1
        addrArr[0] = 5'd5;  dataArr[0] = 32'h50;
        addrArr[1] = 5'd6;  dataArr[1] = 32'h60;
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        applyStimulus(4'b0011, 4'b0001, 1'b0);
        checkOutput("wrap_last_gnt_1", 64'(lastGnt), 64'(1));
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        checkOutput("wrap_last_gnt_0", 64'(lastGnt), 64'(0));

        // Write to register 0: guarded instance drops it, unguarded issues it
        addrArr[2] = 5'd0;
        dataArr[2] = 32'hFFFFFFFF;
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        checkOutput("zg0_gnt", 64'(gnt0), 64'(4'b0100));
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("zg_last_gnt", 64'(lastGnt), 64'(2));
        checkOutput("zg_write", 64'(write), 64'(0));
        checkOutput("zg0_write", 64'(write0), 64'(1));
        checkOutput("zg0_wraddr", 64'(wraddr0), 64'(0));
        checkOutput("zg0_wrdata", 64'(wrdata0), 64'(32'hFFFFFFFF));
        checkOutput("zg0_last_gnt", 64'(lastGnt0), 64'(2));

        // Reset right after a grant with requests held
        addrArr[1] = 5'd7;  dataArr[1] = 32'hA1;
        addrArr[3] = 5'd9;  dataArr[3] = 32'hA3;
        applyStimulus(4'b1010, 4'b1000, 1'b0);
        applyStimulus(4'b1010, 4'b0000, 1'b1);
        checkOutput("mid_rst_inflight", 64'(write), 64'(1));
        applyStimulus(4'b1010, 4'b0010, 1'b0);
        checkOutput("post_rst_write", 64'(write), 64'(0));
        checkOutput("post_rst_last_gnt", 64'(lastGnt), 64'(3));
        applyStimulus(4'b1000, 4'b1000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Random burst of 64 requests with bounded waiting
        pending = 4'b0000;
        issued  = 0;
        cycles  = 0;
        for (int i = 0; i < 4; i++) waitCnt[i] = 0;
        while ((issued < 64 || pending != 4'b0000) && cycles < 2000) begin
            for (int i = 0; i < 4; i++) begin
                if (!pending[i] && issued < 64 && $urandom_range(1, 0) == 1) begin
                    pending[i] = 1'b1;
                    addrArr[i] = 5'($urandom_range(31, 0));
                    dataArr[i] = $urandom;
                    waitCnt[i] = 0;
                    issued++;
                end
            end
            expG = rrModel(pending, modelLast);
            applyStimulus(pending, expG, 1'b0);
            for (int i = 0; i < 4; i++) begin
                if (pending[i]) waitCnt[i]++;
                if (expG[i]) begin
                    totalCount++;
                    if (waitCnt[i] <= 4) passCount++;
                    else $display("[TB] FAIL wait_bound: got %0d cycles expected at most 4", waitCnt[i]);
                    pending[i] = 1'b0;
                end
            end
            cycles++;
        end
        if (cycles >= 2000) begin
            totalCount++;
            $display("[TB] FAIL random_budget: got %0d cycles expected fewer than 2000", cycles);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        checkOutput("queue_drained", 64'(expQ.size()), 64'(0));
        for (int a = 1; a < 32; a++) begin
            if (modelWritten[a]) checkOutput($sformatf("rf[%0d]", a), 64'(rf[a]), 64'(modelRf[a]));
        end

        @(posedge clk);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
